// File: rtl/rpn_pkg.sv
// Shared opcodes, error codes and FSM state encoding for the RPN engine.
// RPN_MUL_EN makes opcode 8 (MUL) a legal binary operator.
package rpn_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_DUP  = 4'd5;
   localparam logic [3:0] OP_DROP = 4'd6;
   localparam logic [3:0] OP_END  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_UNDER   = 2'd1;
   localparam logic [1:0] ERR_OVER    = 2'd2;
   localparam logic [1:0] ERR_ILLEGAL = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StPopB,
      StPopA,
      StExec,
      StDup1,
      StDup2,
      StEmit,
      StErr
   } state_e;

   function automatic logic is_binop(input logic [3:0] op);
      logic r;
      r = (op <= OP_XOR);
`ifdef RPN_MUL_EN
      r = r || (op == OP_MUL);
`endif
      return r;
   endfunction

endpackage

// File: rtl/rpn_lifo.sv
// Clocked LIFO: push writes at the occupancy index, pop registers the top entry into q
// (valid the cycle after the pop). Storage is never cleared by reset.
module rpn_lifo #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned DEPTH = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [DEPTH:0]   count
);

   logic [WIDTH-1:0] mem [2**DEPTH];
   logic [DEPTH-1:0] top;

   assign top = count[DEPTH-1:0] - DEPTH'(1);

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[count[DEPTH-1:0]] <= d;
      end
      if (pop && !reset) begin
         q <= mem[top];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (push) begin
         count <= count + (DEPTH+1)'(1);
      end else if (pop) begin
         count <= count - (DEPTH+1)'(1);
      end
   end

endmodule

// File: rtl/rpn_engine.sv
// Reverse-Polish expression evaluator driving an internal LIFO from a token stream.
// Define RPN_MUL_EN to add opcode 8 (MUL); otherwise opcode 8 is illegal.
module rpn_engine
   import rpn_pkg::*;
#(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned DEPTH = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tok_valid,
   output logic             tok_ready,
   input  logic             tok_is_op,
   input  logic [WIDTH-1:0] tok_data,
   output logic             result_valid,
   output logic [WIDTH-1:0] result,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [DEPTH:0]   depth
);

   localparam logic [DEPTH:0] CAP = (DEPTH+1)'(2**DEPTH);

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q, hold_q, result_q;
   logic             result_valid_q;
   logic [1:0]       err_code_q;
   logic [3:0]       op_q;

   logic [3:0]       opcode;
   logic [1:0]       tok_err;
   logic             lifo_push, lifo_pop;
   logic [WIDTH-1:0] lifo_d, lifo_q, alu;
   logic [DEPTH:0]   count;

   assign opcode       = tok_data[3:0];
   assign tok_ready    = (state_q == StIdle);
   assign err          = (state_q == StErr);
   assign err_code     = err_code_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign depth        = count;

   // Legality of the token currently offered, judged against current occupancy.
   always_comb begin
      tok_err = ERR_NONE;
      if (!tok_is_op) begin
         if (count == CAP) tok_err = ERR_OVER;
      end else if (is_binop(opcode)) begin
         if (count < (DEPTH+1)'(2)) tok_err = ERR_UNDER;
      end else begin
         case (opcode)
            OP_DUP, OP_DROP: begin
               if (count == '0) tok_err = ERR_UNDER;
            end
            OP_END: begin
               if (count == '0) tok_err = ERR_UNDER;
               else if (count > (DEPTH+1)'(1)) tok_err = ERR_OVER;
            end
            default: tok_err = ERR_ILLEGAL;
         endcase
      end
   end

   always_comb begin
      alu = '0;
      case (op_q)
         OP_ADD: alu = a_q + b_q;
         OP_SUB: alu = a_q - b_q;
         OP_AND: alu = a_q & b_q;
         OP_OR:  alu = a_q | b_q;
         OP_XOR: alu = a_q ^ b_q;
`ifdef RPN_MUL_EN
         OP_MUL: alu = a_q * b_q;
`endif
         default: alu = '0;
      endcase
   end

   always_comb begin
      lifo_push = 1'b0;
      lifo_pop  = 1'b0;
      lifo_d    = tok_data;
      unique case (state_q)
         StIdle: begin
            if (tok_valid && tok_err == ERR_NONE) begin
               lifo_push = !tok_is_op;
               lifo_pop  = tok_is_op;
            end
         end
         StPopB: lifo_pop = 1'b1;
         StExec: begin
            lifo_push = 1'b1;
            lifo_d    = alu;
         end
         StDup1: begin
            lifo_push = 1'b1;
            lifo_d    = lifo_q;
         end
         StDup2: begin
            lifo_push = 1'b1;
            lifo_d    = hold_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         a_q            <= '0;
         b_q            <= '0;
         hold_q         <= '0;
         op_q           <= OP_ADD;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         err_code_q     <= ERR_NONE;
      end else begin
         result_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (tok_valid) begin
                  if (tok_err != ERR_NONE) begin
                     state_q    <= StErr;
                     err_code_q <= tok_err;
                  end else if (tok_is_op) begin
                     op_q <= opcode;
                     case (opcode)
                        OP_DUP:  state_q <= StDup1;
                        OP_DROP: state_q <= StIdle;
                        OP_END:  state_q <= StEmit;
                        default: state_q <= StPopB;
                     endcase
                  end
               end
            end
            StPopB: begin
               b_q     <= lifo_q;
               state_q <= StPopA;
            end
            StPopA: begin
               a_q     <= lifo_q;
               state_q <= StExec;
            end
            StExec: state_q <= StIdle;
            StDup1: begin
               hold_q  <= lifo_q;
               state_q <= StDup2;
            end
            StDup2: state_q <= StIdle;
            StEmit: begin
               result_q       <= lifo_q;
               result_valid_q <= 1'b1;
               state_q        <= StIdle;
            end
            StErr: state_q <= StErr;
         endcase
      end
   end

   rpn_lifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_lifo (
      .clk  (clk),
      .reset(reset),
      .push (lifo_push),
      .pop  (lifo_pop),
      .d    (lifo_d),
      .q    (lifo_q),
      .count(count)
   );

endmodule

// File: tb/tb_rpn_engine.sv
// Bench for rpn_engine: token-level stack model checked every cycle, directed
// expressions with literal results, then randomized token streams.
module tb_rpn_engine;

   localparam int W   = 11;
   localparam int D   = 7;
   localparam int CAP = 128;
`ifdef RPN_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         tok_valid = 1'b0;
   logic         tok_is_op = 1'b0;
   logic [W-1:0] tok_data = '0;
   logic         tok_ready, result_valid, err;
   logic [W-1:0] result;
   logic [1:0]   err_code;
   logic [D:0]   depth;

   always #5 clk = ~clk;

   rpn_engine #(
      .WIDTH(W),
      .DEPTH(D)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tok_valid   (tok_valid),
      .tok_ready   (tok_ready),
      .tok_is_op   (tok_is_op),
      .tok_data    (tok_data),
      .result_valid(result_valid),
      .result      (result),
      .err         (err),
      .err_code    (err_code),
      .depth       (depth)
   );

   // Model state: operand stack plus the visible timing of each token kind.
   logic [W-1:0] stk[$];
   bit           live = 1'b0;
   bit           in_err = 1'b0;
   logic [1:0]   exp_code = 2'd0;
   int           busy = 0;
   int           emit_cnt = 0;
   logic [W-1:0] pend = '0;
   logic [W-1:0] exp_result = '0;
   int           rv_count = 0;
   logic [W-1:0] last_res = '0;
   int           n_checks = 0;
   int           n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      stk.delete();
      in_err     = 1'b0;
      exp_code   = 2'd0;
      busy       = 0;
      emit_cnt   = 0;
      exp_result = '0;
   endtask

   task automatic set_err(input logic [1:0] code);
      in_err   = 1'b1;
      exp_code = code;
   endtask

   task automatic model_token(input bit is_op, input logic [W-1:0] data);
      logic [W-1:0] a, b, r;
      logic [3:0]   op;
      op = data[3:0];
      if (!is_op) begin
         if (stk.size() == CAP) set_err(2'd2);
         else stk.push_back(data);
      end else if (op <= 4'd4 || (op == 4'd8 && MUL_EN)) begin
         if (stk.size() < 2) set_err(2'd1);
         else begin
            b = stk.pop_back();
            a = stk.pop_back();
            case (op)
               4'd0:    r = a + b;
               4'd1:    r = a - b;
               4'd2:    r = a & b;
               4'd3:    r = a | b;
               4'd4:    r = a ^ b;
               default: r = a * b;
            endcase
            stk.push_back(r);
            busy = 3;
         end
      end else if (op == 4'd5) begin
         if (stk.size() == 0) set_err(2'd1);
         else begin
            stk.push_back(stk[$]);
            busy = 2;
         end
      end else if (op == 4'd6) begin
         if (stk.size() == 0) set_err(2'd1);
         else void'(stk.pop_back());
      end else if (op == 4'd7) begin
         if (stk.size() == 0) set_err(2'd1);
         else if (stk.size() > 1) set_err(2'd2);
         else begin
            pend     = stk.pop_back();
            busy     = 1;
            emit_cnt = 2;
         end
      end else begin
         set_err(2'd3);
      end
   endtask

   // Compare process: outputs are checked on the falling edge, then any token
   // that will be accepted on the next rising edge is applied to the model.
   always @(negedge clk) begin
      if (live) begin
         chk("tok_ready", 32'(tok_ready), 32'(!in_err && busy == 0));
         chk("err", 32'(err), 32'(in_err));
         chk("err_code", 32'(err_code), in_err ? 32'(exp_code) : 32'd0);
         if (busy == 0) chk("depth", 32'(depth), 32'(stk.size()));
         chk("result_valid", 32'(result_valid), 32'(emit_cnt == 1));
         if (emit_cnt == 1) exp_result = pend;
         chk("result", 32'(result), 32'(exp_result));
         if (result_valid) begin
            rv_count++;
            last_res = result;
         end
         if (busy > 0) busy--;
         if (emit_cnt > 0) emit_cnt--;
      end
      if (reset) begin
         model_reset();
         live = 1'b1;
      end else if (live && tok_valid && tok_ready && !in_err && busy == 0) begin
         model_token(tok_is_op, tok_data);
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_tok(input bit is_op, input logic [W-1:0] data, input int max_wait,
                           output bit got);
      got       = 1'b0;
      tok_valid = 1'b1;
      tok_is_op = is_op;
      tok_data  = data;
      for (int i = 0; i < max_wait; i++) begin
         @(negedge clk);
         if (tok_ready) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      tok_valid = 1'b0;
   endtask

   task automatic opnd(input int v);
      bit got;
      send_tok(1'b0, W'(v), 8, got);
   endtask

   task automatic oper(input int op);
      bit got;
      send_tok(1'b1, W'(op), 8, got);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      tok_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic expect_result(input string name, input logic [W-1:0] exp);
      int start;
      bit seen;
      start = rv_count;
      seen  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (rv_count != start) begin
            seen = 1'b1;
            break;
         end
      end
      chk({name, "_seen"}, 32'(seen), 32'd1);
      chk(name, 32'(last_res), 32'(exp));
      repeat (3) @(negedge clk);
      #1;
      chk({name, "_pulses"}, 32'(rv_count - start), 32'd1);
      chk({name, "_depth"}, 32'(depth), 32'd0);
      sync();
   endtask

   task automatic expect_err(input string name, input logic [1:0] code);
      @(negedge clk);
      #1;
      chk({name, "_err"}, 32'(err), 32'd1);
      chk({name, "_code"}, 32'(err_code), 32'(code));
      sync();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      int low, start;

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_ready", 32'(tok_ready), 32'd1);
      chk("rst_rv", 32'(result_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_code", 32'(err_code), 32'd0);
      chk("rst_depth", 32'(depth), 32'd0);
      sync();

      opnd(3); opnd(4); oper(0);
      low = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (!tok_ready) low++;
         else break;
      end
      chk("add_busy", 32'(low), 32'd3);
      sync();
      oper(7);
      expect_result("add", 11'd7);

      opnd(2); opnd(5); oper(1); oper(7);
      expect_result("sub", 11'd2045);

      oper(0);
      expect_err("add_empty", 2'd1);
      send_tok(1'b0, 11'd5, 5, got);
      chk("err_blocks", 32'(got), 32'd0);
      do_reset();
      @(negedge clk);
      #1;
      chk("rec_ready", 32'(tok_ready), 32'd1);
      chk("rec_err", 32'(err), 32'd0);
      chk("rec_depth", 32'(depth), 32'd0);
      sync();

      for (int i = 0; i < CAP; i++) opnd(i);
      @(negedge clk);
      #1;
      chk("full_depth", 32'(depth), 32'd128);
      chk("full_err", 32'(err), 32'd0);
      sync();
      opnd(999);
      expect_err("overflow", 2'd2);
      do_reset();

      opnd(1); opnd(2); oper(7);
      expect_err("leftover", 2'd2);
      do_reset();

      opnd(6); oper(5); oper(4); oper(7);
      expect_result("dup_xor", 11'd0);
      opnd(7); opnd(8); oper(6); oper(7);
      expect_result("drop", 11'd7);

      start = rv_count;
      opnd(1); opnd(2); oper(0);
      sync();
      do_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("abort_depth", 32'(depth), 32'd0);
      chk("abort_ready", 32'(tok_ready), 32'd1);
      chk("abort_no_rv", 32'(rv_count - start), 32'd0);
      sync();

      opnd(40); opnd(60); oper(8);
`ifdef RPN_MUL_EN
      oper(7);
      expect_result("mul", 11'd352);
`else
      expect_err("mul_off", 2'd3);
      do_reset();
`endif
      oper(12);
      expect_err("op12", 2'd3);
      do_reset();

      for (int n = 0; n < 2500; n++) begin
         int r, sz, k;
         bit is_op;
         logic [W-1:0] v;
         r     = int'($urandom_range(0, 99));
         sz    = stk.size();
         v     = W'($urandom);
         is_op = 1'b1;
         k     = int'($urandom_range(0, MUL_EN ? 5 : 4));
         if (r < 2) v[3:0] = 4'(9 + $urandom_range(0, 6));
         else if (r < 4) v[3:0] = 4'd7;
         else if (r < 6 || (sz >= 2 && (r < 50 || sz >= 120))) v[3:0] = (k == 5) ? 4'd8 : 4'(k);
         else if (sz == 1 && r < 30) v[3:0] = 4'd7;
         else if (sz > 0 && r < 58) v[3:0] = 4'd5;
         else if (sz > 0 && r < 64) v[3:0] = 4'd6;
         else is_op = 1'b0;
         send_tok(is_op, v, 8, got);
         if (in_err) do_reset();
         else if ($urandom_range(0, 149) == 0) do_reset();
         else if ($urandom_range(0, 7) == 0) sync();
      end

      repeat (8) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
